regfile_wb_arbiter: RTL

- Shares the single register-file write port (wen/rd/dataD) between two writeback requesters: A (execute/ALU) and B (load unit).
- Each requester gets a one-entry holding buffer with a valid/ready handshake.
- A round-robin arbiter, with an age override on rd conflicts, drains the buffers into a registered write port.
- Exports a per-register pending mask so decode can stall on RAW hazards. Sits between the writeback stage and register_file.

---
 rtl/regfile_wb_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: two one-entry holding buffers (A=execute, B=load) drained into one registered
// register-file write port. Optional trace/protocol checks are enabled with `define RF_ARB_TRACE_EN.
module regfile_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [ADDR_WIDTH-1:0]      a_rd,
  input  logic [DATA_WIDTH-1:0]      a_data,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [ADDR_WIDTH-1:0]      b_rd,
  input  logic [DATA_WIDTH-1:0]      b_data,
  output logic                       rf_wen,
  output logic [ADDR_WIDTH-1:0]      rf_rd,
  output logic [DATA_WIDTH-1:0]      rf_dataD,
  output logic [(1<<ADDR_WIDTH)-1:0] pending,
  output logic                       idle
);

  localparam int NREG = 1 << ADDR_WIDTH;

  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;

  logic                  a_full_q, a_full_d;
  logic [ADDR_WIDTH-1:0] a_rd_q, a_rd_d;
  logic [DATA_WIDTH-1:0] a_data_q, a_data_d;
  logic                  b_full_q, b_full_d;
  logic [ADDR_WIDTH-1:0] b_rd_q, b_rd_d;
  logic [DATA_WIDTH-1:0] b_data_q, b_data_d;
  logic                  b_older_q, b_older_d;
  src_e                  last_q, last_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_rd_q, rf_rd_d;
  logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;

  logic grant_a, grant_b;
  logic a_load, b_load;
  logic [NREG-1:0] pending_c;

  // Grant is a pure function of buffer state, so ready never depends on valid.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_full_q && b_full_q) begin
      if (a_rd_q != b_rd_q) grant_a = (last_q == SRC_B);
      else                  grant_a = !b_older_q;
      grant_b = !grant_a;
    end else begin
      grant_a = a_full_q;
      grant_b = b_full_q;
    end
  end

  assign a_ready = rst_n && (!a_full_q || grant_a);
  assign b_ready = rst_n && (!b_full_q || grant_b);

  // Writes to x0 complete the handshake but never occupy a buffer.
  assign a_load = a_valid && a_ready && (a_rd != '0);
  assign b_load = b_valid && b_ready && (b_rd != '0);

  always_comb begin
    a_full_d  = a_load ? 1'b1 : (grant_a ? 1'b0 : a_full_q);
    b_full_d  = b_load ? 1'b1 : (grant_b ? 1'b0 : b_full_q);
    a_rd_d    = a_load ? a_rd   : a_rd_q;
    a_data_d  = a_load ? a_data : a_data_q;
    b_rd_d    = b_load ? b_rd   : b_rd_q;
    b_data_d  = b_load ? b_data : b_data_q;
    b_older_d = b_older_q;
    // A newcomer is younger than any entry that stays; a simultaneous load makes B older.
    if (a_load && b_load)  b_older_d = 1'b1;
    else if (a_load)       b_older_d = b_full_q && !grant_b;
    else if (b_load)       b_older_d = !(a_full_q && !grant_a);
    last_d    = last_q;
    if (grant_a)      last_d = SRC_A;
    else if (grant_b) last_d = SRC_B;
    rf_wen_d  = grant_a || grant_b;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    if (grant_a) begin
      rf_rd_d   = a_rd_q;
      rf_data_d = a_data_q;
    end else if (grant_b) begin
      rf_rd_d   = b_rd_q;
      rf_data_d = b_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_full_q  <= 1'b0;
      b_full_q  <= 1'b0;
      b_older_q <= 1'b0;
      last_q    <= SRC_B;
      rf_wen_q  <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
    end else begin
      a_full_q  <= a_full_d;
      b_full_q  <= b_full_d;
      b_older_q <= b_older_d;
      last_q    <= last_d;
      rf_wen_q  <= rf_wen_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
    end
  end

  // Buffer payloads are qualified by their full bits and need no reset.
  always_ff @(posedge clk) begin
    a_rd_q   <= a_rd_d;
    a_data_q <= a_data_d;
    b_rd_q   <= b_rd_d;
    b_data_q <= b_data_d;
  end

  always_comb begin
    pending_c = '0;
    if (a_full_q) pending_c[a_rd_q]  = 1'b1;
    if (b_full_q) pending_c[b_rd_q]  = 1'b1;
    if (rf_wen_q) pending_c[rf_rd_q] = 1'b1;
    pending_c[0] = 1'b0;
  end

  assign pending  = pending_c;
  assign idle     = !a_full_q && !b_full_q && !rf_wen_q;
  assign rf_wen   = rf_wen_q;
  assign rf_rd    = rf_rd_q;
  assign rf_dataD = rf_data_q;

`ifdef RF_ARB_TRACE_EN
  logic trace_src_q;
  logic a_wait_q;
  logic b_wait_q;

  always @(posedge clk) begin
    if (rf_wen_q) begin
      $display("wb%s x%0d <= 0x%h(%0d)", trace_src_q ? "B" : "A", rf_rd_q, rf_data_q,
               $signed(rf_data_q));
      if (rf_rd_q == '0) $error("regfile_wb_arbiter: write issued to x0");
    end
    if (rst_n && a_wait_q && !a_valid) $error("regfile_wb_arbiter: A request withdrawn");
    if (rst_n && b_wait_q && !b_valid) $error("regfile_wb_arbiter: B request withdrawn");
    trace_src_q <= grant_b;
    a_wait_q    <= rst_n && a_valid && !a_ready;
    b_wait_q    <= rst_n && b_valid && !b_ready;
  end
`else
  // Trace disabled: no simulation-only logic.
`endif

endmodule
